// File: rtl/env_pkg.sv
// Shared types and defaults for the per-voice ADSR envelope slice.
// Latency: n/a (declarations only).
// Backpressure: n/a; the envelope path has no flow control.
package env_pkg;

    localparam int DEF_WIDTH    = 16;
    localparam int DEF_TICK_DIV = 1024;
    localparam int NOTE_SEL_W   = 3;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ATTACK  = 3'd1,
        DECAY   = 3'd2,
        SUSTAIN = 3'd3,
        RELEASE = 3'd4
    } env_state_t;

endpackage

// File: rtl/adsr_envelope_if.sv
// Bundle of the note-decoder controls, envelope rates and envelope outputs for one voice.
// Latency: n/a (wiring only).
// Backpressure: none; the gate, trigger and rates are plain levels and strobes.
interface adsr_envelope_if
    import env_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic                  gate_in;
    logic                  trigger_in;
    logic [NOTE_SEL_W-1:0] note_sel_in;
    logic [WIDTH-1:0]      attack_rate_in;
    logic [WIDTH-1:0]      decay_rate_in;
    logic [WIDTH-1:0]      sustain_level_in;
    logic [WIDTH-1:0]      release_rate_in;
    logic [WIDTH-1:0]      env_out;
    logic [NOTE_SEL_W-1:0] note_out;
    logic                  active_out;
    logic                  done_out;

    // Note decoder / control side: drives gate, trigger, note and rates.
    modport master (
        output gate_in, trigger_in, note_sel_in,
        output attack_rate_in, decay_rate_in, sustain_level_in, release_rate_in,
        input  env_out, note_out, active_out, done_out
    );

    // Envelope generator side.
    modport slave (
        input  gate_in, trigger_in, note_sel_in,
        input  attack_rate_in, decay_rate_in, sustain_level_in, release_rate_in,
        output env_out, note_out, active_out, done_out
    );

endinterface

// File: rtl/env_tick_gen.sv
// Envelope step prescaler: counts 0..TICK_DIV-1 and flags the last count as a tick.
// Latency: tick is combinational from the count register; restart takes effect at the next edge.
// Backpressure: none; free-running apart from the synchronous restart.
module env_tick_gen #(
    parameter int TICK_DIV = 1024
) (
    input  logic clk_in,
    input  logic rst_n_in,
    input  logic restart,
    output logic tick
);
    localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;

    assign tick = (cnt_q == CNT_LAST);

    // Prescaler count: restart wins, otherwise wrap after the tick count.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            cnt_q <= '0;
        end else if (restart || tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/adsr_envelope.sv
// Per-voice ADSR envelope: saturating attack/decay/release steps on prescaler ticks, sustain tracks level live.
// Latency: all outputs registered; first envelope step lands TICK_DIV+1 cycles after an accepted trigger.
// Backpressure: none; triggers with gate low are dropped. Define ADSR_RETRIGGER_EN for legato retrigger.
module adsr_envelope
    import env_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int TICK_DIV = DEF_TICK_DIV
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    adsr_envelope_if.slave   env_if
);
    localparam logic [WIDTH-1:0] ENV_MAX = '1;

`ifdef ADSR_RETRIGGER_EN
    localparam bit RETRIG_EN = 1'b1;
`else
    localparam bit RETRIG_EN = 1'b0;
`endif

    env_state_t            state_q, state_nxt;
    logic [WIDTH-1:0]      env_q, env_nxt;
    logic [NOTE_SEL_W-1:0] note_q, note_nxt;
    logic                  active_q, active_nxt;
    logic                  done_q, done_nxt;

    logic                  tick;
    logic                  acc_trig;
    logic                  take_trig;
    logic                  in_hold_phase;

    logic [WIDTH:0]        att_sum;
    logic [WIDTH:0]        dec_diff;
    logic [WIDTH:0]        rel_diff;
    logic                  att_sat;
    logic                  dec_hit;
    logic                  rel_hit;

    env_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .restart  (take_trig),
        .tick     (tick)
    );

    assign acc_trig      = env_if.trigger_in & env_if.gate_in;
    assign in_hold_phase = (state_q == ATTACK) || (state_q == DECAY) || (state_q == SUSTAIN);
    assign take_trig     = acc_trig &&
                           ((state_q == IDLE) || (state_q == RELEASE) || (RETRIG_EN && in_hold_phase));

    // One extra bit on every step so overflow and borrow are visible before clamping.
    assign att_sum  = {1'b0, env_q} + {1'b0, env_if.attack_rate_in};
    assign dec_diff = {1'b0, env_q} - {1'b0, env_if.decay_rate_in};
    assign rel_diff = {1'b0, env_q} - {1'b0, env_if.release_rate_in};
    assign att_sat  = (att_sum >= {1'b0, ENV_MAX});
    assign dec_hit  = dec_diff[WIDTH] || (dec_diff[WIDTH-1:0] <= env_if.sustain_level_in);
    assign rel_hit  = rel_diff[WIDTH] || (rel_diff[WIDTH-1:0] == '0);

    // State register; reset mid-envelope always returns to IDLE.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Next state: gate fall beats everything, then trigger, then the tick-driven step.
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            IDLE: begin
                if (take_trig) state_nxt = ATTACK;
            end
            ATTACK: begin
                if (!env_if.gate_in)      state_nxt = RELEASE;
                else if (take_trig)       state_nxt = ATTACK;
                else if (tick && att_sat) state_nxt = DECAY;
            end
            DECAY: begin
                if (!env_if.gate_in)      state_nxt = RELEASE;
                else if (take_trig)       state_nxt = ATTACK;
                else if (tick && dec_hit) state_nxt = SUSTAIN;
            end
            SUSTAIN: begin
                if (!env_if.gate_in)      state_nxt = RELEASE;
                else if (take_trig)       state_nxt = ATTACK;
            end
            RELEASE: begin
                if (take_trig)            state_nxt = ATTACK;
                else if (tick && rel_hit) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output/datapath next values; a trigger or gate fall freezes env for that cycle.
    always_comb begin
        env_nxt  = env_q;
        note_nxt = note_q;
        if (take_trig) note_nxt = env_if.note_sel_in;
        case (state_q)
            ATTACK: begin
                if (env_if.gate_in && !take_trig && tick)
                    env_nxt = att_sat ? ENV_MAX : att_sum[WIDTH-1:0];
            end
            DECAY: begin
                if (env_if.gate_in && !take_trig && tick)
                    env_nxt = dec_hit ? env_if.sustain_level_in : dec_diff[WIDTH-1:0];
            end
            SUSTAIN: begin
                if (env_if.gate_in && !take_trig)
                    env_nxt = env_if.sustain_level_in;
            end
            RELEASE: begin
                if (!take_trig && tick)
                    env_nxt = rel_hit ? '0 : rel_diff[WIDTH-1:0];
            end
            default: env_nxt = env_q;
        endcase
        active_nxt = (state_nxt != IDLE);
        done_nxt   = (state_q == RELEASE) && (state_nxt == IDLE);
    end

    // Output registers.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            env_q    <= '0;
            note_q   <= '0;
            active_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            env_q    <= env_nxt;
            note_q   <= note_nxt;
            active_q <= active_nxt;
            done_q   <= done_nxt;
        end
    end

    assign env_if.env_out    = env_q;
    assign env_if.note_out   = note_q;
    assign env_if.active_out = active_q;
    assign env_if.done_out   = done_q;

endmodule

// File: tb/tb_adsr_envelope.sv
// Directed bench for adsr_envelope at WIDTH=16, TICK_DIV=4.
// Latency: n/a.
// Backpressure: n/a.
module tb_adsr_envelope;
    import env_pkg::*;

    logic clk_in;
    logic rst_n_in;
    int   n_checks;
    int   n_fail;

    adsr_envelope_if #(.WIDTH(16)) env_if ();

    adsr_envelope #(
        .WIDTH    (16),
        .TICK_DIV (4)
    ) dut (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .env_if   (env_if)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance n rising edges and settle 1 time unit after the last one.
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    task automatic set_rates(input logic [15:0] a, input logic [15:0] d,
                             input logic [15:0] s, input logic [15:0] r);
        env_if.attack_rate_in   = a;
        env_if.decay_rate_in    = d;
        env_if.sustain_level_in = s;
        env_if.release_rate_in  = r;
    endtask

    // Issue a one-cycle accepted trigger; returns one cycle after it (T+1).
    task automatic press(input logic [2:0] note);
        env_if.gate_in     = 1'b1;
        env_if.trigger_in  = 1'b1;
        env_if.note_sel_in = note;
        cyc(1);
        env_if.trigger_in  = 1'b0;
    endtask

    initial begin
        logic [15:0] prev_env;
        int          steps;
        int          dones;

        n_checks = 0;
        n_fail   = 0;
        env_if.gate_in     = 1'b0;
        env_if.trigger_in  = 1'b0;
        env_if.note_sel_in = 3'd0;
        set_rates(16'h0, 16'h0, 16'h0, 16'h0);

        // Reset then idle
        rst_n_in = 1'b0;
        #1;
        check("rst_env", env_if.env_out, 0);
        check("rst_note", env_if.note_out, 0);
        check("rst_active", env_if.active_out, 0);
        check("rst_done", env_if.done_out, 0);
        cyc(3);
        rst_n_in = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cyc(1);
            check("idle_env", env_if.env_out, 0);
            check("idle_active", env_if.active_out, 0);
            check("idle_done", env_if.done_out, 0);
        end

        // Trigger without gate is ignored
        env_if.trigger_in  = 1'b1;
        env_if.note_sel_in = 3'd6;
        cyc(1);
        env_if.trigger_in  = 1'b0;
        check("nogate_active", env_if.active_out, 0);
        check("nogate_note", env_if.note_out, 0);

        // Full ADSR
        set_rates(16'h4000, 16'h1000, 16'h8000, 16'h2000);
        press(3'd5);                               // now T+1
        check("adsr_note", env_if.note_out, 5);
        check("adsr_active", env_if.active_out, 1);
        check("adsr_env_t1", env_if.env_out, 16'h0000);
        cyc(4);  check("adsr_env_t5", env_if.env_out, 16'h4000);
        cyc(3);  check("adsr_env_t8", env_if.env_out, 16'h4000);
        cyc(1);  check("adsr_env_t9", env_if.env_out, 16'h8000);
        cyc(4);  check("adsr_env_t13", env_if.env_out, 16'hC000);
        cyc(4);  check("adsr_env_t17", env_if.env_out, 16'hFFFF);
        cyc(28); check("adsr_env_t45", env_if.env_out, 16'h8FFF);
        cyc(4);  check("adsr_env_t49", env_if.env_out, 16'h8000);
        cyc(8);  check("adsr_sustain_hold", env_if.env_out, 16'h8000);
        env_if.sustain_level_in = 16'h7000;
        cyc(1);  check("sustain_track_lo", env_if.env_out, 16'h7000);
        env_if.sustain_level_in = 16'h8000;
        cyc(1);  check("sustain_track_hi", env_if.env_out, 16'h8000);
        env_if.gate_in = 1'b0;
        cyc(1);
        check("rel_entry_active", env_if.active_out, 1);
        check("rel_entry_env", env_if.env_out, 16'h8000);
        prev_env = 16'h8000;
        steps = 0;
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            cyc(1);
            if (env_if.env_out != prev_env) begin
                steps++;
                check("rel_step", env_if.env_out, prev_env - 16'h2000);
                prev_env = env_if.env_out;
            end
            if (env_if.done_out) begin
                dones++;
                check("done_env", env_if.env_out, 0);
                check("done_active", env_if.active_out, 0);
            end
        end
        check("rel_steps", steps, 4);
        check("done_pulses", dones, 1);

        // Saturation and floors
        set_rates(16'hFFFF, 16'h0000, 16'h8000, 16'hFFFF);
        press(3'd1);
        cyc(4);  check("att_sat", env_if.env_out, 16'hFFFF);
        cyc(8);  check("decay_rate0_hold", env_if.env_out, 16'hFFFF);
        env_if.decay_rate_in = 16'h7FFF;
        cyc(4);  check("decay_to_sustain", env_if.env_out, 16'h8000);
        env_if.gate_in = 1'b0;
        cyc(1);  check("floor_entry", env_if.env_out, 16'h8000);
        cyc(4);
        check("rel_floor", env_if.env_out, 0);
        check("rel_floor_active", env_if.active_out, 0);

        // Early release, gate re-rise without trigger, then reset mid-release
        set_rates(16'h4000, 16'h1000, 16'h8000, 16'h1000);
        press(3'd4);
        cyc(4);  check("early_att", env_if.env_out, 16'h4000);
        env_if.gate_in = 1'b0;
        cyc(1);
        check("early_rel_env", env_if.env_out, 16'h4000);
        check("early_rel_active", env_if.active_out, 1);
        cyc(3);  check("early_rel_step", env_if.env_out, 16'h3000);
        env_if.gate_in = 1'b1;
        cyc(4);  check("gate_rerise_noeffect", env_if.env_out, 16'h2000);
        rst_n_in = 1'b0;
        #1;
        check("midrel_rst_env", env_if.env_out, 0);
        check("midrel_rst_active", env_if.active_out, 0);
        check("midrel_rst_note", env_if.note_out, 0);
        env_if.gate_in = 1'b0;
        cyc(2);
        rst_n_in = 1'b1;
        cyc(2);
        check("post_rst_active", env_if.active_out, 0);

        // Retrigger from SUSTAIN
        set_rates(16'hFFFF, 16'h7FFF, 16'h8000, 16'h1000);
        press(3'd3);
        cyc(8);  check("retrig_sustain", env_if.env_out, 16'h8000);
        env_if.attack_rate_in = 16'h1000;
        press(3'd2);
`ifdef ADSR_RETRIGGER_EN
        check("retrig_note", env_if.note_out, 2);
        cyc(4);  check("retrig_env", env_if.env_out, 16'h9000);
`else
        check("retrig_note", env_if.note_out, 3);
        cyc(4);  check("retrig_env", env_if.env_out, 16'h8000);
`endif
        check("retrig_active", env_if.active_out, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/adsr_envelope.md
# adsr_envelope

- Per-voice ADSR amplitude envelope generator.
- Consumes the gate/trigger/note-select triple produced by the front-panel note decoding stage.
- Produces an unsigned amplitude word that scales the oscillator output downstream, and latches the note index alongside it so the voice's oscillator and envelope stay paired.

## Interface

Parameters:
- WIDTH, 16, envelope/level width in bits
- TICK_DIV, 1024, clock cycles per envelope step (≥2)

Ports:
- clk_in  input  1  system clock
- rst_n_in  input  1  reset, asynchronous assert, active-low
- gate_in  input  1  key held (level)
- trigger_in  input  1  key-press strobe, one cycle
- note_sel_in  input  3  note index from note decoding
- attack_rate_in  input  WIDTH  increment per tick in ATTACK
- decay_rate_in  input  WIDTH  decrement per tick in DECAY
- sustain_level_in  input  WIDTH  sustain target level
- release_rate_in  input  WIDTH  decrement per tick in RELEASE
- env_out  output  WIDTH  current envelope level
- note_out  output  3  note index latched on accepted trigger
- active_out  output  1  high when state ≠ IDLE
- done_out  output  1  one-cycle pulse on RELEASE→IDLE

## Operation

- States: IDLE, ATTACK, DECAY, SUSTAIN, RELEASE.
- Accepted trigger = trigger_in & gate_in. A trigger with gate_in low is ignored.
- IDLE:
  - On accepted trigger → ATTACK.
  - Latch note_out.
  - Restart the tick prescaler.
- ATTACK, on tick:
  - env = min(env + attack_rate, ENV_MAX), where ENV_MAX = 2^WIDTH−1.
  - Sum computed at WIDTH+1 bits.
  - Reaching ENV_MAX → DECAY.
- DECAY, on tick:
  - env = max(env − decay_rate, sustain_level), computed with a borrow bit.
  - Reaching sustain_level → SUSTAIN.
  - If env is already ≤ sustain_level on entry → SUSTAIN at the next tick; env is set to sustain_level.
- SUSTAIN:
  - env tracks sustain_level_in every cycle, without waiting for a tick.
- RELEASE, on tick:
  - env = max(env − release_rate, 0).
  - Reaching 0 → IDLE and pulse done_out.
- Gate low in ATTACK, DECAY or SUSTAIN → RELEASE on the next clock, with no tick required. env continues from its current value.
- gate_in returning high during RELEASE without a trigger: no effect.
- Rate of 0 holds env at its current value indefinitely. This is legal, not an error.
- Accepted trigger in RELEASE:
  - → ATTACK from the current env.
  - Relatch note_out.
  - Restart the prescaler.
- Accepted trigger in ATTACK, DECAY or SUSTAIN: handled by ADSR_RETRIGGER_EN.
- Trigger and gate-fall in the same cycle cannot occur, because an accepted trigger requires gate_in high.
- Rate inputs are sampled only on tick cycles.

## Timing

- Reset values (asynchronous, while rst_n_in low):
  - state IDLE, env_out 0, note_out 0, active_out 0, done_out 0, prescaler 0.
- Reset deasserted mid-envelope: the block restarts in IDLE. No envelope state is retained.
- All outputs are registered.
- Accepted trigger at cycle T:
  - active_out and note_out update at T+1.
  - First tick at T+TICK_DIV; env_out reflects it at T+TICK_DIV+1.
- Prescaler:
  - Counts 0..TICK_DIV−1 and wraps; tick is asserted when the count equals TICK_DIV−1.
  - Free-running except for the restarts listed in Operation.
- Gate fall at cycle T → state RELEASE at T+1. First release step occurs at the next tick after T+1.
- done_out is high for exactly the cycle in which state becomes IDLE. It coincides with env_out = 0 and active_out falling.

## Configuration

- ADSR_RETRIGGER_EN defined: an accepted trigger in ATTACK, DECAY or SUSTAIN:
  - → ATTACK from the current env (legato retrigger).
  - Relatch note_out.
  - Restart the prescaler.
- ADSR_RETRIGGER_EN undefined:
  - Such triggers are ignored; note_out and the envelope are unchanged.
  - Retrigger is possible only from IDLE or RELEASE.

## Structure

- Shared package env_pkg:
  - env_state_t enum (IDLE, ATTACK, DECAY, SUSTAIN, RELEASE).
  - Default WIDTH and TICK_DIV constants.
  - NOTE_SEL_W = 3.
- Sub-module env_tick_gen: parameterised prescaler with a synchronous restart input and a one-cycle tick output.
- adsr_envelope contains the state machine and saturating datapath.

## Test plan

All scenarios use WIDTH=16, TICK_DIV=4.

- Reset then idle:
  - Stimulus: rst_n_in low for 3 cycles, then high, no trigger for 20 cycles.
  - Response: env_out=0, active_out=0, done_out=0 throughout.
- Full ADSR:
  - Stimulus: attack=0x4000, decay=0x1000, sustain=0x8000, release=0x2000. Trigger with note_sel_in=5 at T, then hold gate.
  - Response:
    - note_out=5 at T+1.
    - env_out=0x4000 at T+5, 0xC000 at T+13, 0xFFFF at T+17.
    - Then decays to 0x8000 and holds.
  - Stimulus: drop gate.
  - Response: env falls 0x2000 per tick to 0; done_out pulses once.
- Saturation and floors:
  - Stimulus: attack=0xFFFF.
  - Response: env_out=0xFFFF after one tick, with no wrap.
  - Stimulus: release=0xFFFF from env 0x8000.
  - Response: env_out=0 after one tick, with no underflow.
- Early release:
  - Stimulus: gate falls during ATTACK at env=0x4000.
  - Response: state RELEASE next cycle; env decreases from 0x4000.
- Retrigger:
  - Stimulus: trigger with note_sel_in=2 during SUSTAIN at env 0x8000.
  - Response with the macro: note_out=2; env rises from 0x8000.
  - Response without the macro: no change.
- Reset mid-release:
  - Stimulus: assert rst_n_in during RELEASE.
  - Response: env_out=0 and active_out=0 immediately, without waiting for a clock edge.
